// File: rtl/pe_ctrl.sv
// pe_ctrl: sequences filter load, per-window 16-pixel MAC, lane packing and output-word writes for one PE
module pe_ctrl #(
  parameter int OUT_DEPTH = 172,
  parameter int ADDR_W = $clog2(OUT_DEPTH),
  parameter int CNT_W = $clog2(4*OUT_DEPTH+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_outputs,
  input  logic              filt_valid,
  input  logic              win_valid,
  output logic              busy,
  output logic              win_next,
  output logic              filter_wr_en,
  output logic [1:0]        write_filter_buff_ind,
  output logic [3:0]        pixel_ind,
  output logic              mac_en,
  output logic              mac_clr,
  output logic              shift_reg_en,
  output logic              finalize_shift_reg,
  output logic              memory_wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              done
);
  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_WAIT, S_MAC, S_SHIFT, S_PCLR, S_PSH, S_FINAL, S_WRITE, S_DONE
  } state_t;
  localparam logic [CNT_W-1:0] MAX_N = CNT_W'(4*OUT_DEPTH);
  state_t state, state_n;
  logic [1:0] row, row_n, lane, lane_n;
  logic [3:0] pix, pix_n;
  logic [CNT_W-1:0] res, res_n, n, n_n, clamp;
  logic [ADDR_W-1:0] addr, addr_n;
  assign clamp = num_outputs > MAX_N ? MAX_N : num_outputs;
  // State and counter registers; reset abandons any partial word
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      row <= '0;
      lane <= '0;
      pix <= '0;
      res <= '0;
      n <= '0;
      addr <= '0;
    end else begin
      state <= state_n;
      row <= row_n;
      lane <= lane_n;
      pix <= pix_n;
      res <= res_n;
      n <= n_n;
      addr <= addr_n;
    end
  end
  // Next-state and counter updates; lane wraps to 0 after the fourth push
  always_comb begin
    state_n = state;
    row_n = row;
    lane_n = lane;
    pix_n = pix;
    res_n = res;
    n_n = n;
    addr_n = addr;
    case (state)
      S_IDLE: if (start) begin
        n_n = clamp;
        res_n = '0;
        lane_n = '0;
        row_n = '0;
        addr_n = '0;
        state_n = clamp == '0 ? S_DONE : S_LOAD;
      end
      S_LOAD: if (filt_valid) begin
        row_n = row + 2'd1;
        state_n = row == 2'd3 ? S_WAIT : S_LOAD;
      end
      S_WAIT: if (win_valid) begin
        pix_n = '0;
        state_n = S_MAC;
      end
      S_MAC: begin
        pix_n = pix + 4'd1;
        state_n = pix == 4'd15 ? S_SHIFT : S_MAC;
      end
      S_SHIFT: begin
        lane_n = lane + 2'd1;
        res_n = res + 1'b1;
        state_n = lane == 2'd3 ? S_FINAL : (res + 1'b1 == n ? S_PCLR : S_WAIT);
      end
      S_PCLR: state_n = S_PSH;
      S_PSH: begin
        lane_n = lane + 2'd1;
        state_n = lane == 2'd3 ? S_FINAL : S_PSH;
      end
      S_FINAL: state_n = S_WRITE;
      S_WRITE: begin
        lane_n = '0;
        addr_n = res == n ? '0 : addr + 1'b1;
        state_n = res == n ? S_DONE : S_WAIT;
      end
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end
  assign busy = state != S_IDLE;
  assign win_next = state == S_SHIFT;
  assign filter_wr_en = state == S_LOAD && filt_valid;
  assign write_filter_buff_ind = state == S_LOAD ? row : 2'd0;
  assign pixel_ind = state == S_MAC ? pix : 4'd0;
  assign mac_en = state == S_MAC;
  assign mac_clr = (state == S_WAIT && win_valid) || state == S_PCLR;
  assign shift_reg_en = state == S_SHIFT || state == S_PSH;
  assign finalize_shift_reg = state == S_FINAL;
  assign memory_wr_en = state == S_WRITE;
  assign wr_addr = addr;
  assign done = state == S_DONE;
endmodule

// File: tb/tb_pe_ctrl.sv
// tb_pe_ctrl: directed self-checking bench for pe_ctrl
module tb_pe_ctrl;
  localparam int CW = 10;
  localparam int AW = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic [CW-1:0] num_outputs = '0;
  logic filt_valid, win_valid;
  logic busy, win_next, filter_wr_en, mac_en, mac_clr, shift_reg_en;
  logic finalize_shift_reg, memory_wr_en, done;
  logic [1:0] write_filter_buff_ind;
  logic [3:0] pixel_ind;
  logic [AW-1:0] wr_addr;
  logic [22:0] outs;
  int cyc = 0, start_cyc = 0, rel;
  int win_lo = 0, win_hi = 0, filt_lo = 0, filt_hi = 0;
  int fw_cnt = 0, mac_cnt = 0, clr_cnt = 0, sh_cnt = 0, wn_cnt = 0, wr_cnt = 0;
  int done_cnt = 0, pix_bad = 0, stall_act = 0, last_addr = 0;
  int b_fw, b_mac, b_clr, b_sh, b_wn, b_wr, b_done, b_stall;
  logic [7:0] fw_rows = '0;
  logic [15:0] a_hist = '0;
  logic [3:0] pexp = '0;
  int checks = 0, fails = 0, got;
  pe_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .num_outputs(num_outputs),
    .filt_valid(filt_valid), .win_valid(win_valid), .busy(busy), .win_next(win_next),
    .filter_wr_en(filter_wr_en), .write_filter_buff_ind(write_filter_buff_ind),
    .pixel_ind(pixel_ind), .mac_en(mac_en), .mac_clr(mac_clr), .shift_reg_en(shift_reg_en),
    .finalize_shift_reg(finalize_shift_reg), .memory_wr_en(memory_wr_en),
    .wr_addr(wr_addr), .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign rel = cyc - start_cyc;
  assign win_valid = !(rel >= win_lo && rel < win_hi);
  assign filt_valid = !(rel >= filt_lo && rel < filt_hi);
  assign outs = {busy, win_next, filter_wr_en, write_filter_buff_ind, pixel_ind, mac_en, mac_clr,
                 shift_reg_en, finalize_shift_reg, memory_wr_en, wr_addr, done};
  always @(negedge clk) begin
    if (filter_wr_en) begin
      fw_cnt <= fw_cnt + 1;
      fw_rows <= {fw_rows[5:0], write_filter_buff_ind};
    end
    if (mac_en) begin
      mac_cnt <= mac_cnt + 1;
      pexp <= pexp + 4'd1;
      if (pixel_ind != pexp) pix_bad <= pix_bad + 1;
    end else pexp <= '0;
    if (mac_clr) clr_cnt <= clr_cnt + 1;
    if (shift_reg_en) sh_cnt <= sh_cnt + 1;
    if (win_next) wn_cnt <= wn_cnt + 1;
    if (memory_wr_en) begin
      wr_cnt <= wr_cnt + 1;
      last_addr <= int'(wr_addr);
      a_hist <= {a_hist[7:0], wr_addr};
    end
    if (done) done_cnt <= done_cnt + 1;
    if (((mac_en || mac_clr) && rel >= win_lo && rel < win_hi) ||
        (filter_wr_en && rel >= filt_lo && rel < filt_hi)) stall_act <= stall_act + 1;
  end
  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask
  task automatic snap();
    b_fw = fw_cnt; b_mac = mac_cnt; b_clr = clr_cnt; b_sh = sh_cnt;
    b_wn = wn_cnt; b_wr = wr_cnt; b_done = done_cnt; b_stall = stall_act;
  endtask
  task automatic start_job(input int n);
    @(posedge clk); #1;
    start_cyc = cyc;
    num_outputs = CW'(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    num_outputs = CW'(3);
  endtask
  task automatic wait_done(input int budget, output int r);
    r = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        r = rel;
        break;
      end
    end
    @(posedge clk); #1;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_outs", int'(outs), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("idle_outs", int'(outs), 0);
    snap();
    start_job(4);
    check("a_busy", int'(busy), 1);
    wait_done(300, got);
    check("a_done_cyc", got, 79);
    check("a_fw", fw_cnt - b_fw, 4);
    check("a_rows", int'(fw_rows), 8'h1B);
    check("a_mac", mac_cnt - b_mac, 64);
    check("a_shift", sh_cnt - b_sh, 4);
    check("a_winnext", wn_cnt - b_wn, 4);
    check("a_wr", wr_cnt - b_wr, 1);
    check("a_addr", last_addr, 0);
    check("a_donecnt", done_cnt - b_done, 1);
    check("a_idle", int'(busy), 0);
    snap();
    start_job(6);
    wait_done(400, got);
    check("b_done_cyc", got, 120);
    check("b_wr", wr_cnt - b_wr, 2);
    check("b_addrs", int'(a_hist), 16'h0001);
    check("b_shift", sh_cnt - b_sh, 8);
    check("b_winnext", wn_cnt - b_wn, 6);
    check("b_clr", clr_cnt - b_clr, 7);
    check("b_mac", mac_cnt - b_mac, 96);
    snap();
    start_job(0);
    wait_done(20, got);
    check("c_done_cyc", got, 1);
    check("c_fw", fw_cnt - b_fw, 0);
    check("c_mac", mac_cnt - b_mac, 0);
    check("c_wr", wr_cnt - b_wr, 0);
    check("c_donecnt", done_cnt - b_done, 1);
    win_lo = 5; win_hi = 15;
    snap();
    start_job(4);
    wait_done(300, got);
    check("d_done_cyc", got, 89);
    check("d_stall_act", stall_act - b_stall, 0);
    check("d_mac", mac_cnt - b_mac, 64);
    check("d_wr", wr_cnt - b_wr, 1);
    win_lo = 0; win_hi = 0;
    filt_lo = 2; filt_hi = 12;
    snap();
    start_job(4);
    wait_done(300, got);
    check("e_done_cyc", got, 89);
    check("e_stall_act", stall_act - b_stall, 0);
    check("e_fw", fw_cnt - b_fw, 4);
    check("e_rows", int'(fw_rows), 8'h1B);
    filt_lo = 0; filt_hi = 0;
    snap();
    start_job(4);
    repeat (44) @(posedge clk);
    #1;
    check("f_in_mac", int'(mac_en), 1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("f_rst_outs", int'(outs), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    check("f_wr", wr_cnt - b_wr, 0);
    check("f_donecnt", done_cnt - b_done, 0);
    snap();
    start_job(4);
    wait_done(300, got);
    check("f2_done_cyc", got, 79);
    check("f2_fw", fw_cnt - b_fw, 4);
    check("f2_rows", int'(fw_rows), 8'h1B);
    check("f2_addr", last_addr, 0);
    check("f2_wr", wr_cnt - b_wr, 1);
    snap();
    start_job(1000);
    repeat (100) @(posedge clk);
    #1;
    num_outputs = CW'(4);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(20000, got);
    check("g_done_cyc", got, 12733);
    repeat (20) @(posedge clk);
    #1;
    check("g_idle", int'(busy), 0);
    check("g_donecnt", done_cnt - b_done, 1);
    check("g_wr", wr_cnt - b_wr, 172);
    check("g_last_addr", last_addr, 171);
    check("g_addrs", int'(a_hist), 16'hAAAB);
    check("g_shift", sh_cnt - b_sh, 688);
    check("g_winnext", wn_cnt - b_wn, 688);
    check("pix_seq_bad", pix_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
